// File: rtl/display_scan_ctrl.sv
// Scans four BCD digits through one shared 7-segment decoder, one slot per digit with a dark gap.
// Define BLINK_EN to add the blink input and BLINK_FRAMES parameter.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_GAP = 500
`ifdef BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
`ifdef BLINK_EN
    input  logic        blink,
`endif
    output logic [3:0]  dig_nibble,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] GapLast = CntW'(BLANK_GAP - 1);
    localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StOff, StGap, StOn} state_e;

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       pend_val_q, pend_val_d;
    logic              pending_q, pending_d;
    logic [3:0]        an_n_q, an_n_d;
    logic [3:0]        nib_q, nib_d;
    logic              fd_q;
    logic              wrap;
    logic              lz;
    logic [3:0]        val;

`ifdef BLINK_EN
    localparam int unsigned FrameW = $clog2(BLINK_FRAMES) + 1;
    logic              visible_q, visible_d;
    logic [FrameW-1:0] fcnt_q, fcnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pending_d  = pending_q;
        wrap       = 1'b0;

        if (!enable) begin
            state_d = StOff;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StOff: begin
                    state_d = StGap;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
                StGap: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == GapLast) state_d = StOn;
                end
                StOn: begin
                    if (cnt_q == DivLast) begin
                        state_d = StGap;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        wrap    = (idx_q == 2'd3);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StOff;
            endcase
        end

        // The wrap commit happens first so a load on the same edge stays pending for the next frame.
        if (wrap && pending_q) begin
            shadow_d  = pend_val_q;
            pending_d = 1'b0;
        end
        if (load) begin
            if (state_q == StOff) begin
                shadow_d = digits_in;
            end else begin
                pend_val_d = digits_in;
                pending_d  = 1'b1;
            end
        end
    end

`ifdef BLINK_EN
    always_comb begin
        visible_d = visible_q;
        fcnt_d    = fcnt_q;
        if (!blink) begin
            visible_d = 1'b1;
            fcnt_d    = '0;
        end else if (wrap) begin
            if (fcnt_q == FrameW'(BLINK_FRAMES - 1)) begin
                fcnt_d    = '0;
                visible_d = ~visible_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end
`endif

    // Outputs are registered from next-state so they line up with the state they describe.
    always_comb begin
        lz = 1'b0;
        unique case (idx_d)
            2'd3:    lz = (shadow_d[15:12] == 4'h0);
            2'd2:    lz = (shadow_d[15:8] == 8'h00);
            2'd1:    lz = (shadow_d[15:4] == 12'h000);
            default: lz = 1'b0;
        endcase
        val = (blank_lz && lz) ? 4'hF : shadow_d[{idx_d, 2'b00} +: 4];

        an_n_d = 4'b1111;
        nib_d  = 4'hF;
        case (state_d)
            StGap: nib_d = val;
            StOn: begin
                nib_d  = val;
                an_n_d = ~(4'b0001 << idx_d);
            end
            default: begin
                an_n_d = 4'b1111;
                nib_d  = 4'hF;
            end
        endcase
`ifdef BLINK_EN
        if (blink && !visible_d) an_n_d = 4'b1111;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StOff;
            idx_q      <= 2'd0;
            cnt_q      <= '0;
            shadow_q   <= 16'h0000;
            pend_val_q <= 16'h0000;
            pending_q  <= 1'b0;
            an_n_q     <= 4'b1111;
            nib_q      <= 4'hF;
            fd_q       <= 1'b0;
`ifdef BLINK_EN
            visible_q  <= 1'b1;
            fcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pending_q  <= pending_d;
            an_n_q     <= an_n_d;
            nib_q      <= nib_d;
            fd_q       <= wrap;
`ifdef BLINK_EN
            visible_q  <= visible_d;
            fcnt_q     <= fcnt_d;
`endif
        end
    end

    assign an_n       = an_n_q;
    assign dig_nibble = nib_q;
    assign frame_done = fd_q;

endmodule
